// File: rtl/prefetch_pkg.sv
// rtl/prefetch_pkg.sv - shared state and queue-entry types for the instruction prefetch unit
package prefetch_pkg;

    // Entry width; prefetch_unit's XLEN must match.
    localparam int unsigned PF_XLEN = 32;

    typedef enum logic [0:0] {
        ST_FETCH = 1'b0,
        ST_FAULT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [PF_XLEN-1:0] data;
        logic [PF_XLEN-1:0] pc;
        logic               fault;
    } pf_entry_t;

endpackage

// File: rtl/prefetch_fifo.sv
// rtl/prefetch_fifo.sv - DEPTH-entry instruction queue with push/pop/flush and occupancy count
module prefetch_fifo
    import prefetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  pf_entry_t                push_data_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output pf_entry_t                head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    pf_entry_t         mem_q [DEPTH];
    logic [AW-1:0]     wr_q, wr_d;
    logic [AW-1:0]     rd_q, rd_d;
    logic [CW-1:0]     count_q, count_d;
    logic              do_push;
    logic              do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_q];

    // A pop frees the slot the simultaneous push needs, so push+pop is legal when full.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (flush_i) begin
            wr_d    = '0;
            rd_d    = '0;
            count_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + AW'(1);
            if (do_pop)  rd_d = rd_q + AW'(1);
            if (do_push && !do_pop)      count_d = count_q + CW'(1);
            else if (!do_push && do_pop) count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_q] <= push_data_i;
    end

endmodule

// File: rtl/prefetch_unit.sv
// rtl/prefetch_unit.sv - credit-based instruction prefetcher with redirect flush/drain; PREFETCH_MISALIGN_CHECK_EN enables misaligned-target faults
module prefetch_unit
    import prefetch_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr_data,
    output logic [XLEN-1:0] instr_pc,
    output logic [XLEN-1:0] instr_pc_plus4,
    output logic            instr_fault
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    fetch_state_t      state_q, state_d;
    logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]     inflight_q, inflight_d;
    logic [CW-1:0]     drop_q, drop_d;
    logic [XLEN-1:0]   pcq_mem_q [DEPTH];
    logic [AW-1:0]     pcq_wr_q, pcq_wr_d;
    logic [AW-1:0]     pcq_rd_q, pcq_rd_d;

    logic              req_hs;
    logic              rsp_keep;
    logic              fault_push;
    logic              credit_ok;
    logic [XLEN-1:0]   redir_target;
    logic              fifo_push;
    logic              fifo_pop;
    pf_entry_t         fifo_wdata;
    pf_entry_t         fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;

    // Queue slots are reserved at request time so a response always has room.
    assign credit_ok      = ({1'b0, fifo_count} + {1'b0, inflight_q}) < (CW+1)'(DEPTH);
    assign imem_req_valid = !rst && (state_q == ST_FETCH) && credit_ok;
    assign imem_req_addr  = fetch_pc_q;
    assign req_hs         = imem_req_valid && imem_req_ready;
    assign rsp_keep       = imem_rsp_valid && (drop_q == '0) && !redirect_valid;

`ifdef PREFETCH_MISALIGN_CHECK_EN
    logic fault_pend_q, fault_pend_d;

    assign redir_target = redirect_pc;
    assign fault_push   = (state_q == ST_FAULT) && fault_pend_q && (inflight_q == '0) && !redirect_valid;
    assign instr_fault  = instr_valid && fifo_head.fault;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) fault_pend_q <= 1'b0;
        else     fault_pend_q <= fault_pend_d;
    end
`else
    logic unused_fault;

    assign redir_target = redirect_pc & ~XLEN'(3);
    assign fault_push   = 1'b0;
    assign instr_fault  = 1'b0;
    assign unused_fault = fifo_head.fault;
`endif

    always_comb begin
        state_d = state_q;
`ifdef PREFETCH_MISALIGN_CHECK_EN
        fault_pend_d = fault_pend_q;
        if (redirect_valid) begin
            if (redirect_pc[1:0] != 2'b00) begin
                state_d      = ST_FAULT;
                fault_pend_d = 1'b1;
            end else begin
                state_d      = ST_FETCH;
                fault_pend_d = 1'b0;
            end
        end else if (fault_push) begin
            fault_pend_d = 1'b0;
        end
`endif
    end

    always_comb begin
        inflight_d = inflight_q;
        if (req_hs && !imem_rsp_valid)      inflight_d = inflight_q + CW'(1);
        else if (!req_hs && imem_rsp_valid) inflight_d = inflight_q - CW'(1);

        // Everything still outstanding after a redirect belongs to the old path.
        drop_d = drop_q;
        if (redirect_valid)                         drop_d = inflight_d;
        else if (imem_rsp_valid && drop_q != '0)    drop_d = drop_q - CW'(1);

        fetch_pc_d = fetch_pc_q;
        if (redirect_valid) fetch_pc_d = redir_target;
        else if (req_hs)    fetch_pc_d = fetch_pc_q + XLEN'(4);

        pcq_wr_d = req_hs         ? pcq_wr_q + AW'(1) : pcq_wr_q;
        pcq_rd_d = imem_rsp_valid ? pcq_rd_q + AW'(1) : pcq_rd_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_FETCH;
            fetch_pc_q <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
            pcq_wr_q   <= '0;
            pcq_rd_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            pcq_wr_q   <= pcq_wr_d;
            pcq_rd_q   <= pcq_rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (req_hs) pcq_mem_q[pcq_wr_q] <= fetch_pc_q;
    end

    always_comb begin
        fifo_wdata = '0;
        if (fault_push) begin
            fifo_wdata.pc    = PF_XLEN'(fetch_pc_q);
            fifo_wdata.fault = 1'b1;
        end else begin
            fifo_wdata.data = PF_XLEN'(imem_rsp_data);
            fifo_wdata.pc   = PF_XLEN'(pcq_mem_q[pcq_rd_q]);
        end
    end

    assign fifo_push = rsp_keep || fault_push;
    assign fifo_pop  = instr_valid && instr_ready && !redirect_valid;

    prefetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (fifo_push),
        .push_data_i (fifo_wdata),
        .pop_i       (fifo_pop),
        .flush_i     (redirect_valid),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    assign instr_valid    = !fifo_empty;
    assign instr_data     = XLEN'(fifo_head.data);
    assign instr_pc       = XLEN'(fifo_head.pc);
    assign instr_pc_plus4 = instr_pc + XLEN'(4);

    logic unused_full;
    assign unused_full = fifo_full;

endmodule

// File: tb/tb_prefetch_unit.sv
// tb/tb_prefetch_unit.sv - scoreboard bench for prefetch_unit with an in-order variable-latency memory model
module tb_prefetch_unit;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            instr_valid;
    logic            instr_ready;
    logic [XLEN-1:0] instr_data;
    logic [XLEN-1:0] instr_pc;
    logic [XLEN-1:0] instr_pc_plus4;
    logic            instr_fault;

    prefetch_unit #(
        .XLEN     (XLEN),
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc),
        .instr_pc_plus4 (instr_pc_plus4),
        .instr_fault    (instr_fault)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        logic        fault;
    } exp_t;
    exp_t exp_q[$];
    logic [31:0] next_pc;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;
    mreq_t mq[$];
    int lat = 1;
    int total_hs = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_A5A5;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Memory: accepts handshakes, answers in order after `lat` cycles, one beat per cycle.
    initial begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            if (!rst && imem_req_valid && imem_req_ready) begin
                mq.push_back('{imem_req_addr, cyc + lat});
                total_hs++;
            end
            @(posedge clk);
            #1;
            if (rst) begin
                mq.delete();
                imem_rsp_valid = 1'b0;
            end else begin
                if (imem_rsp_valid && mq.size() != 0) void'(mq.pop_front());
                if (mq.size() != 0 && mq[0].due <= cyc) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = mem_word(mq[0].addr);
                end else begin
                    imem_rsp_valid = 1'b0;
                end
            end
        end
    end

    // Monitor: every accepted instruction is popped from the scoreboard and compared.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && instr_valid && instr_ready && !redirect_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_instr: got pc %h expected none", instr_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("instr_pc", instr_pc, e.pc);
                    chk("instr_data", instr_data, e.data);
                    chk("instr_pc_plus4", instr_pc_plus4, e.pc + 32'd4);
                    chk("instr_fault", 32'(instr_fault), 32'(e.fault));
                end
            end
        end
    end

    task automatic push_exp(input logic [31:0] pc, input logic [31:0] data, input logic fault);
        exp_q.push_back('{pc, data, fault});
    endtask

    task automatic wait_drain(output int used);
        used = 0;
        instr_ready = 1'b1;
        while (exp_q.size() != 0 && used < 200) begin
            @(posedge clk);
            #1;
            used++;
        end
        instr_ready = 1'b0;
        chk("drain_done", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic drain(input int n, output int used);
        for (int i = 0; i < n; i++) begin
            push_exp(next_pc, mem_word(next_pc), 1'b0);
            next_pc = next_pc + 32'd4;
        end
        wait_drain(used);
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        instr_ready    = 1'b0;
        imem_req_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr_fault", 32'(instr_fault), 32'd0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        total_hs = 0;
        next_pc  = 32'h0;
    endtask

    // One-cycle redirect; the request port is held off so no old-path request is issued in it.
    task automatic redirect(input logic [31:0] pc);
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int used;
        int hs_base;
        logic ok;
        logic [31:0] held;

        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        instr_ready    = 1'b0;
        imem_req_ready = 1'b1;

        // Reset, first request, steady one-per-cycle stream.
        do_reset();
        @(negedge clk);
        chk("first_req_valid", 32'(imem_req_valid), 32'd1);
        chk("first_req_addr", imem_req_addr, 32'h0);
        drain(8, used);
        chk("steady_rate_cycles", 32'(used), 32'd10);

        // Decode stall: queue fills to DEPTH and requests stop.
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
        chk("stall_instr_valid", 32'(instr_valid), 32'd1);
        chk("stall_total_requests", 32'(total_hs), 32'(8 + DEPTH));
        @(posedge clk);
        #1;
        drain(6, used);

        // Redirect, then memory back-pressure: address must hold.
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        ok = 1'b1;
        held = 32'h200;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (!imem_req_valid || imem_req_addr !== held) ok = 1'b0;
            @(posedge clk);
            #1;
        end
        chk("req_addr_held", 32'(ok), 32'd1);
        imem_req_ready = 1'b1;
        next_pc = 32'h200;
        drain(3, used);

        // fetch_pc wraps past the top of the address space.
        redirect(32'hFFFF_FFF8);
        next_pc = 32'hFFFF_FFF8;
        drain(4, used);

        // Misaligned target.
`ifdef PREFETCH_MISALIGN_CHECK_EN
        redirect(32'h102);
        push_exp(32'h102, 32'h0, 1'b1);
        wait_drain(used);
        hs_base = total_hs;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("fault_req_valid", 32'(imem_req_valid), 32'd0);
        chk("fault_no_requests", 32'(total_hs - hs_base), 32'd0);
        @(posedge clk);
        #1;
        redirect(32'h200);
        next_pc = 32'h200;
        drain(2, used);
`else
        redirect(32'h102);
        next_pc = 32'h100;
        drain(2, used);
`endif

        // Redirect with two requests outstanding: both responses must be discarded.
        lat = 3;
        do_reset();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("inflight_at_redirect", 32'(total_hs), 32'd2);
        redirect(32'h100);
        lat = 1;
        next_pc = 32'h100;
        drain(4, used);

        // Reset with queued entries and requests in flight.
        lat = 4;
        redirect(32'h300);
        hs_base = total_hs;
        ok = 1'b0;
        for (int i = 0; i < 12 && !ok; i++) begin
            @(negedge clk);
            if (instr_valid) ok = 1'b1;
        end
        chk("queued_before_reset", 32'(ok), 32'd1);
        chk("requests_before_reset", 32'(total_hs - hs_base), 32'd4);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("async_rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("async_rst_instr_fault", 32'(instr_fault), 32'd0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        total_hs = 0;
        lat      = 1;
        next_pc  = 32'h0;
        @(negedge clk);
        chk("restart_req_valid", 32'(imem_req_valid), 32'd1);
        chk("restart_req_addr", imem_req_addr, 32'h0);
        @(posedge clk);
        #1;
        drain(3, used);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
